// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Purpose: bundles the request, ALU, writeback and branch signals of the
//          ALU sequencer into one interface.
// Modports:
//   slave  - the sequencer: takes requests, ALU results and branch queries;
//            drives req_ready, the ALU operands and select, writeback, ccr
//            and the branch result.
//   master - the decode / register-file / ALU side. It is the mirror image
//            of slave.
// Parameter: DST_W - width of the destination register index.
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int unsigned DST_W = 2
);
    // request channel
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic [DST_W-1:0] req_dst;

    // ALU channel
    logic [7:0]       alu_data_A;
    logic [7:0]       alu_data_B;
    logic [3:0]       alu_sel;
    logic [7:0]       alu_result;
    logic [3:0]       alu_nzvc;

    // writeback / status
    logic             wb_valid;
    logic [7:0]       wb_data;
    logic [DST_W-1:0] wb_dst;
    logic             op_err;
    logic [3:0]       ccr;

    // branch resolution
    logic             br_valid;
    logic [3:0]       br_cond;
    logic             br_done;
    logic             br_taken;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dst,
        input  alu_result, alu_nzvc,
        input  br_valid, br_cond,
        output req_ready,
        output alu_data_A, alu_data_B, alu_sel,
        output wb_valid, wb_data, wb_dst, op_err, ccr,
        output br_done, br_taken
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_dst,
        output alu_result, alu_nzvc,
        output br_valid, br_cond,
        input  req_ready,
        input  alu_data_A, alu_data_B, alu_sel,
        input  wb_valid, wb_data, wb_dst, op_err, ccr,
        input  br_done, br_taken
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Purpose: the issuing side of an 8-bit combinational ALU. It accepts one
//          operation request, drives the ALU, captures Result and NZVC,
//          updates the condition-code register and emits a register-file
//          writeback. It also resolves branch conditions against the CCR.
// Ports:
//   clock - single clock; all state changes on the rising edge.
//   reset - synchronous reset, active low.
//   bus   - alu_sequencer_if.slave:
//           request channel (req_*), ALU channel (alu_*),
//           writeback (wb_*, op_err, ccr) and branch channel (br_*).
// Configuration macro: CCR_BYPASS_EN
//   defined   - a branch evaluated in the EXEC cycle sees the flags that are
//               about to be written into the CCR.
//   undefined - a branch always sees the registered CCR.
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int unsigned DST_W   = 2,
    parameter int unsigned NUM_OPS = 9
) (
    input  logic           clock,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [DATA_W-1:0]   r_alu_a,     w_alu_a;
    logic [DATA_W-1:0]   r_alu_b,     w_alu_b;
    logic [SEL_W-1:0]    r_alu_sel,   w_alu_sel;
    logic [DST_W-1:0]    r_dst,       w_dst;
    logic                r_wb_valid,  w_wb_valid;
    logic [DATA_W-1:0]   r_wb_data,   w_wb_data;
    logic [DST_W-1:0]    r_wb_dst,    w_wb_dst;
    logic                r_op_err,    w_op_err;
    logic [FLAG_W-1:0]   r_ccr,       w_ccr;
    logic                r_br_done,   w_br_done;
    logic                r_br_taken,  w_br_taken;

    logic                w_req_ready;
    logic                w_op_legal;
    logic                w_full_mask;
    logic [FLAG_W-1:0]   w_ccr_upd;
    logic [FLAG_W-1:0]   w_br_flags;

    // Branch condition decode; flags are {N,Z,V,C}; codes 9..15 never take.
    function automatic logic f_cond(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
        logic taken;
        case (cond)
            4'd0:    taken = 1'b1;
            4'd1:    taken = f[2];
            4'd2:    taken = ~f[2];
            4'd3:    taken = f[3];
            4'd4:    taken = ~f[3];
            4'd5:    taken = f[1];
            4'd6:    taken = ~f[1];
            4'd7:    taken = f[0];
            4'd8:    taken = ~f[0];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Holding reset low also masks req_ready, so nothing is accepted during reset.
    assign w_req_ready = (r_state == S_IDLE) && reset;

    // Classify the issued op. Arithmetic ops own V and C. Logic ops only own N and Z.
    assign w_op_legal  = (32'(r_alu_sel) < NUM_OPS);
    assign w_full_mask = r_alu_sel inside {4'd0, 4'd1, 4'd7, 4'd8};

    // Compute the CCR value that the EXEC->WB edge would write.
    always_comb begin
        w_ccr_upd = r_ccr;
        if (w_op_legal) begin
            if (w_full_mask) begin
                w_ccr_upd = bus.alu_nzvc;
            end else begin
                w_ccr_upd = {bus.alu_nzvc[3:2], r_ccr[1:0]};
            end
        end
    end

    // Choose the flags that a branch is evaluated against.
`ifdef CCR_BYPASS_EN
    assign w_br_flags = (r_state == S_EXEC) ? w_ccr_upd : r_ccr;
`else
    assign w_br_flags = r_ccr;
`endif

    // Next state and next register values.
    always_comb begin
        w_state_nxt = r_state;
        w_alu_a     = r_alu_a;
        w_alu_b     = r_alu_b;
        w_alu_sel   = r_alu_sel;
        w_dst       = r_dst;
        w_wb_valid  = 1'b0;
        w_wb_data   = r_wb_data;
        w_wb_dst    = r_wb_dst;
        w_op_err    = 1'b0;
        w_ccr       = r_ccr;
        w_br_done   = bus.br_valid;
        w_br_taken  = bus.br_valid && f_cond(bus.br_cond, w_br_flags);

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && w_req_ready) begin
                    w_alu_sel   = bus.req_op;
                    w_alu_a     = bus.req_a;
                    w_alu_b     = bus.req_b;
                    w_dst       = bus.req_dst;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_ccr = w_ccr_upd;
                if (w_op_legal) begin
                    w_wb_data  = bus.alu_result;
                    w_wb_dst   = r_dst;
                    w_wb_valid = 1'b1;
                end else begin
                    w_op_err   = 1'b1;
                end
                w_state_nxt = S_WB;
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_dst      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_dst   <= '0;
            r_op_err   <= 1'b0;
            r_ccr      <= '0;
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_alu_a    <= w_alu_a;
            r_alu_b    <= w_alu_b;
            r_alu_sel  <= w_alu_sel;
            r_dst      <= w_dst;
            r_wb_valid <= w_wb_valid;
            r_wb_data  <= w_wb_data;
            r_wb_dst   <= w_wb_dst;
            r_op_err   <= w_op_err;
            r_ccr      <= w_ccr;
            r_br_done  <= w_br_done;
            r_br_taken <= w_br_taken;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.alu_data_A = r_alu_a;
    assign bus.alu_data_B = r_alu_b;
    assign bus.alu_sel    = r_alu_sel;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_data    = r_wb_data;
    assign bus.wb_dst     = r_wb_dst;
    assign bus.op_err     = r_op_err;
    assign bus.ccr        = r_ccr;
    assign bus.br_done    = r_br_done;
    assign bus.br_taken   = r_br_taken;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Purpose: self-checking bench for alu_sequencer.
// The table supplies each request and the ALU response for it, together
// with the expected writeback and CCR values. Hand-written sequences cover
// the branch decode, back-to-back issue, the EXEC-cycle branch and a reset
// that arrives mid-operation.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    alu_sequencer_if #(.DST_W(2)) bus ();

    alu_sequencer #(
        .DST_W   (2),
        .NUM_OPS (9)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] dst;
        logic [7:0] res;      // ALU Result to present
        logic [3:0] nzvc;     // ALU NZVC to present
        logic       exp_wb;   // 1: wb_valid expected, 0: op_err expected
        logic [7:0] exp_data;
        logic [3:0] exp_ccr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request and follow it through EXEC, WB and back to IDLE.
    task automatic run_op(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        bus.req_a      = v.a;
        bus.req_b      = v.b;
        bus.req_dst    = v.dst;
        bus.alu_result = v.res;
        bus.alu_nzvc   = v.nzvc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, "_sel"},        32'(bus.alu_sel),    32'(v.op));
        chk({tag, "_A"},          32'(bus.alu_data_A), 32'(v.a));
        chk({tag, "_B"},          32'(bus.alu_data_B), 32'(v.b));
        chk({tag, "_ready_exec"}, 32'(bus.req_ready),  32'd0);
        chk({tag, "_wb_early"},   32'(bus.wb_valid),   32'd0);
        @(negedge clk);
        chk({tag, "_wb_valid"},   32'(bus.wb_valid),   32'(v.exp_wb));
        chk({tag, "_op_err"},     32'(bus.op_err),     32'(!v.exp_wb));
        chk({tag, "_wb_data"},    32'(bus.wb_data),    32'(v.exp_data));
        chk({tag, "_ccr"},        32'(bus.ccr),        32'(v.exp_ccr));
        chk({tag, "_ready_wb"},   32'(bus.req_ready),  32'd0);
        if (v.exp_wb) chk({tag, "_wb_dst"}, 32'(bus.wb_dst), 32'(v.dst));
        @(negedge clk);
        chk({tag, "_wb_clr"},     32'(bus.wb_valid),   32'd0);
        chk({tag, "_err_clr"},    32'(bus.op_err),     32'd0);
        chk({tag, "_ready_back"}, 32'(bus.req_ready),  32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [15:0] br_exp;
        logic        exp_bypass;
        vec_t        v;
        total = 0;
        bad   = 0;

        //          op     a      b      dst   res    nzvc     wb    data   ccr
        vecs[0] = '{4'd0, 8'h7F, 8'h01, 2'd1, 8'h80, 4'b1010, 1'b1, 8'h80, 4'b1010}; // ADD
        vecs[1] = '{4'd1, 8'h05, 8'h05, 2'd2, 8'h00, 4'b0100, 1'b1, 8'h00, 4'b0100}; // SUB
        vecs[2] = '{4'd4, 8'hF0, 8'h0F, 2'd3, 8'h00, 4'b0111, 1'b1, 8'h00, 4'b0100}; // AND, V/C held
        vecs[3] = '{4'd8, 8'h00, 8'h00, 2'd0, 8'hFF, 4'b1011, 1'b1, 8'hFF, 4'b1011}; // DEC
        vecs[4] = '{4'd6, 8'h80, 8'h00, 2'd1, 8'h80, 4'b1000, 1'b1, 8'h80, 4'b1011}; // XOR, V/C held
        vecs[5] = '{4'hC, 8'h12, 8'h34, 2'd2, 8'h55, 4'b1111, 1'b0, 8'h80, 4'b1011}; // illegal
        vecs[6] = '{4'd7, 8'h7F, 8'h00, 2'd3, 8'h80, 4'b1010, 1'b1, 8'h80, 4'b1010}; // INC
        vecs[7] = '{4'd5, 8'h00, 8'h00, 2'd0, 8'h00, 4'b0100, 1'b1, 8'h00, 4'b0110}; // OR, V/C held
        vecs[8] = '{4'd9, 8'hAA, 8'h55, 2'd1, 8'h77, 4'b0101, 1'b0, 8'h00, 4'b0110}; // first illegal code
        vecs[9] = '{4'd2, 8'h01, 8'h02, 2'd2, 8'h01, 4'b0000, 1'b1, 8'h01, 4'b0010}; // LAND

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_dst    = '0;
        bus.alu_result = '0;
        bus.alu_nzvc   = '0;
        bus.br_valid   = 1'b0;
        bus.br_cond    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(bus.req_ready),  32'd0);
        chk("rst_ccr",    32'(bus.ccr),        32'd0);
        chk("rst_wb",     32'(bus.wb_valid),   32'd0);
        chk("rst_wbdata", 32'(bus.wb_data),    32'd0);
        chk("rst_err",    32'(bus.op_err),     32'd0);
        chk("rst_brdone", 32'(bus.br_done),    32'd0);
        chk("rst_sel",    32'(bus.alu_sel),    32'd0);
        chk("rst_A",      32'(bus.alu_data_A), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.req_ready), 32'd1);

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // Branch decode against ccr = 0010 (N0 Z0 V1 C0).
        br_exp = 16'h0135;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("br%0d_idle", c), 32'(bus.br_done), 32'd0);
            bus.br_valid = 1'b1;
            bus.br_cond  = 4'(c);
            @(negedge clk);
            bus.br_valid = 1'b0;
            chk($sformatf("br%0d_done", c),  32'(bus.br_done),  32'd1);
            chk($sformatf("br%0d_taken", c), 32'(bus.br_taken), 32'(br_exp[c]));
        end
        @(negedge clk);
        chk("br_taken_clr", 32'(bus.br_taken), 32'd0);

        // Hold req_valid high: a request should be accepted every third cycle.
        bus.req_valid  = 1'b1;
        bus.req_op     = 4'd0;
        bus.req_a      = 8'h01;
        bus.req_b      = 8'h01;
        bus.req_dst    = 2'd3;
        bus.alu_result = 8'h02;
        bus.alu_nzvc   = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("tp%0d_ready", k), 32'(bus.req_ready), 32'((k % 3) == 0));
            chk($sformatf("tp%0d_wb", k),    32'(bus.wb_valid),  32'((k % 3) == 2));
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("tp_ccr", 32'(bus.ccr), 32'd0);

        // A compare followed by a branch in its EXEC cycle. The prior ccr has Z=0.
`ifdef CCR_BYPASS_EN
        exp_bypass = 1'b1;
`else
        exp_bypass = 1'b0;
`endif
        bus.req_valid  = 1'b1;
        bus.req_op     = 4'd1;
        bus.req_a      = 8'h10;
        bus.req_b      = 8'h10;
        bus.req_dst    = 2'd0;
        bus.alu_result = 8'h00;
        bus.alu_nzvc   = 4'b0100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.br_valid  = 1'b1;
        bus.br_cond   = 4'd1;
        @(negedge clk);
        chk("byp_done",  32'(bus.br_done),  32'd1);
        chk("byp_taken", 32'(bus.br_taken), 32'(exp_bypass));
        chk("byp_ccr",   32'(bus.ccr),      32'b0100);
        bus.br_cond = 4'd12;
        @(negedge clk);
        chk("never_done",  32'(bus.br_done),  32'd1);
        chk("never_taken", 32'(bus.br_taken), 32'd0);
        bus.br_valid = 1'b0;
        @(negedge clk);
        chk("br_end_done", 32'(bus.br_done), 32'd0);

        // Reset asserted in EXEC. The op and a pending branch are both dropped.
        bus.req_valid  = 1'b1;
        bus.req_op     = 4'd0;
        bus.req_a      = 8'hF0;
        bus.req_b      = 8'h0F;
        bus.req_dst    = 2'd1;
        bus.alu_result = 8'hFF;
        bus.alu_nzvc   = 4'b1000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.br_valid  = 1'b1;
        bus.br_cond   = 4'd0;
        rst_n         = 1'b0;
        @(negedge clk);
        bus.br_valid = 1'b0;
        chk("mr_wb",     32'(bus.wb_valid),  32'd0);
        chk("mr_err",    32'(bus.op_err),    32'd0);
        chk("mr_ccr",    32'(bus.ccr),       32'd0);
        chk("mr_brdone", 32'(bus.br_done),   32'd0);
        chk("mr_ready",  32'(bus.req_ready), 32'd0);
        chk("mr_sel",    32'(bus.alu_sel),   32'd0);
        @(negedge clk);
        chk("mr_ready2", 32'(bus.req_ready), 32'd0);
        chk("mr_wb2",    32'(bus.wb_valid),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("mr_ready_rel", 32'(bus.req_ready), 32'd1);

        // Normal operation resumes after reset.
        v = '{4'd0, 8'hFF, 8'h04, 2'd2, 8'h03, 4'b0001, 1'b1, 8'h03, 4'b0001};
        run_op(v, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
